// File: rtl/ser_pkg.sv
// Constants and types shared by both ends of the serial link.
package ser_pkg;

  localparam logic [6:0] PREAMBLE = 7'b0111110;
  localparam int         PRE_LEN  = 7;
  localparam logic       IDLE_LVL = 1'b1;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-time divider: tick marks the last clk of each bit time, counted from en rising.
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while disabled, so every enable starts a fresh bit time.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == CNT_LAST) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (CLKS_PER_BIT == 1) ? 1'b1 : (en && cnt_q == CNT_LAST);

endmodule

// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: 7-bit start marker, DATA_W payload bits, then forced idle gap.
// Handshake: a word is taken on a rising clk edge where tx_valid && tx_ready; tx_ready is high only in IDLE.
module ser_frame_tx
  import ser_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              serOut,
  output logic              busy,
  output logic              done,
  output tx_state_t         dbg_state
);

  localparam int IDX_W = $clog2(max3(PRE_LEN, DATA_W, GAP_BITS) + 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_out_q, ser_out_d;
  logic              bit_tick;
  logic [2:0]        pre_pos;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (bit_tick)
  );

  // serOut is registered, so each branch loads the bit for the coming bit time.
  assign pre_pos = 3'(PRE_LEN - 2) - idx_q[2:0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    ser_out_d = ser_out_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        ser_out_d = IDLE_LVL;
        if (tx_valid) begin
          state_d   = PRE;
          idx_d     = '0;
          shift_d   = data_in;
          ser_out_d = PREAMBLE[PRE_LEN-1];
        end
      end
      PRE: begin
        if (bit_tick) begin
          if (idx_q == PRE_LAST) begin
            state_d   = DATA;
            idx_d     = '0;
            ser_out_d = head_bit(shift_q);
          end else begin
            idx_d     = idx_q + 1'b1;
            ser_out_d = PREAMBLE[pre_pos];
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == DATA_LAST) begin
            done      = 1'b1;
            state_d   = GAP;
            idx_d     = '0;
            ser_out_d = IDLE_LVL;
          end else begin
            shift_d   = advance(shift_q);
            idx_d     = idx_q + 1'b1;
            ser_out_d = head_bit(advance(shift_q));
          end
        end
      end
      GAP: begin
        ser_out_d = IDLE_LVL;
        if (bit_tick) begin
          if (idx_q == GAP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        idx_d     = '0;
        ser_out_d = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      ser_out_q <= IDLE_LVL;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      ser_out_q <= ser_out_d;
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign serOut    = ser_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: three configurations share clk/rst; a per-instance monitor
// deserialises serOut and checks each frame against a queue of hand-computed bit patterns.
module tb_ser_frame_tx;
  import ser_pkg::*;

  localparam int GAP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       tx_valid = 3'b000;
  logic [7:0]       data_in [3];
  wire  [2:0]       tx_ready, ser_out, busy, done;
  tx_state_t        dbg0, dbg1, dbg2;

  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               spurious [3];
  bit   [2:0]       mon_en = 3'b111;

  logic [14:0]      exp_q[$];
  int               exp_t_q[$];
  int               exp_k_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ser_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .GAP_BITS(GAP), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .data_in(data_in[0]), .serOut(ser_out[0]), .busy(busy[0]), .done(done[0]),
    .dbg_state(dbg0));

  ser_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .GAP_BITS(GAP), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .data_in(data_in[1]), .serOut(ser_out[1]), .busy(busy[1]), .done(done[1]),
    .dbg_state(dbg1));

  ser_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .GAP_BITS(GAP), .MSB_FIRST(1)) u_slow (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .data_in(data_in[2]), .serOut(ser_out[2]), .busy(busy[2]), .done(done[2]),
    .dbg_state(dbg2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input int k, input logic [7:0] w, input logic [14:0] frame,
                      input bit hold, input bit push, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    tx_valid[k] = 1'b1;
    data_in[k]  = w;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_%0d: tx_ready stayed 0, expected 1", k);
      tx_valid[k] = 1'b0;
      return;
    end
    acc = cyc;
    if (push) begin
      exp_q.push_back(frame);
      exp_t_q.push_back(cyc + 1);
      exp_k_q.push_back(k);
    end
    @(negedge clk);
    if (!hold) begin
      tx_valid[k] = 1'b0;
      data_in[k]  = ~w;
    end
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (busy[k] === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout_%0d: busy=%0b pending=%0d, expected idle", k, busy[k], exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor(input int k, input int cpb);
    logic [14:0] frame, cap;
    int start, done_cyc, done_hits, tag;
    bit held_ok, gap_ok;
    logic b;
    forever begin
      @(negedge clk);
      if (rst || !mon_en[k]) continue;
      if (ser_out[k] === 1'b1) begin
        if (done[k] === 1'b1) spurious[k]++;
        continue;
      end
      if (exp_q.size() == 0 || exp_k_q[0] != k) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_%0d: serOut went 0 at cycle %0d, expected no frame", k, cyc);
        for (int i = 0; i < 400 && busy[k] === 1'b1; i++) @(negedge clk);
        continue;
      end
      frame = exp_q.pop_front();
      start = exp_t_q.pop_front();
      tag   = exp_k_q.pop_front();
      check($sformatf("start_cycle_%0d", tag), cyc, start);
      cap = '0;
      held_ok = 1'b1;
      done_cyc = -1;
      done_hits = 0;
      for (int bi = 0; bi < 15; bi++) begin
        for (int c = 0; c < cpb; c++) begin
          if (bi != 0 || c != 0) @(negedge clk);
          b = ser_out[k];
          if (c == 0) cap = {cap[13:0], b};
          else if (b !== cap[0]) held_ok = 1'b0;
          if (done[k] === 1'b1) begin
            done_hits++;
            done_cyc = cyc;
          end
        end
      end
      check($sformatf("frame_bits_%0d", k), cap, frame);
      check($sformatf("bit_hold_%0d", k), held_ok, 1'b1);
      check($sformatf("done_count_%0d", k), done_hits, 1);
      check($sformatf("done_cycle_%0d", k), done_cyc, start + 15 * cpb - 1);
      gap_ok = 1'b1;
      for (int i = 0; i < GAP * cpb; i++) begin
        @(negedge clk);
        if (ser_out[k] !== 1'b1 || tx_ready[k] !== 1'b0 || done[k] !== 1'b0) gap_ok = 1'b0;
      end
      check($sformatf("gap_idle_%0d", k), gap_ok, 1'b1);
      @(negedge clk);
      check($sformatf("ready_after_gap_%0d", k), tx_ready[k], 1'b1);
    end
  endtask

  initial begin
    fork
      monitor(0, 1);
      monitor(1, 1);
      monitor(2, 4);
    join_none
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, dummy, done_seen;
    for (int k = 0; k < 3; k++) begin
      data_in[k]  = 8'h00;
      spurious[k] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // T1: reset asserted while idle
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t1_serout_%0d", k), ser_out[k], 1'b1);
      check($sformatf("t1_ready_%0d", k), tx_ready[k], 1'b1);
      check($sformatf("t1_busy_%0d", k), busy[k], 1'b0);
      check($sformatf("t1_done_%0d", k), done[k], 1'b0);
    end
    check("t1_state", dbg0, IDLE);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T2: MSB first, 1 clk per bit
    send(0, 8'hA5, 15'b0111110_10100101, 1'b0, 1'b1, dummy);
    wait_idle(0);

    // T3: LSB first
    send(1, 8'h01, 15'b0111110_10000000, 1'b0, 1'b1, dummy);
    wait_idle(1);
    send(1, 8'h0F, 15'b0111110_11110000, 1'b0, 1'b1, dummy);
    wait_idle(1);

    // T4: 4 clks per bit
    send(2, 8'hFF, 15'b0111110_11111111, 1'b0, 1'b1, dummy);
    wait_idle(2);

    // T5: tx_valid held across two words
    send(0, 8'h3C, 15'b0111110_00111100, 1'b1, 1'b1, a1);
    send(0, 8'hC3, 15'b0111110_11000011, 1'b0, 1'b1, a2);
    check("t5_accept_spacing", a2 - a1, 18);
    wait_idle(0);

    // T6: reset during payload bit 3 (A5 -> payload bit 3 is 0)
    mon_en[0] = 1'b0;
    send(0, 8'hA5, 15'b0, 1'b0, 1'b0, a1);
    repeat (10) @(negedge clk);
    check("t6_bit3_before_rst", ser_out[0], 1'b0);
    done_seen = 0;
    rst = 1'b1;
    #1;
    check("t6_serout_async", ser_out[0], 1'b1);
    check("t6_busy", busy[0], 1'b0);
    check("t6_ready", tx_ready[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (done[0] === 1'b1) done_seen++;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done[0] === 1'b1 || ser_out[0] !== 1'b1) done_seen++;
      @(negedge clk);
    end
    check("t6_no_done_idle_line", done_seen, 0);
    mon_en[0] = 1'b1;
    @(negedge clk);
    send(0, 8'h81, 15'b0111110_10000001, 1'b0, 1'b1, dummy);
    wait_idle(0);

    // drain
    check("drain_pending", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) check($sformatf("stray_done_%0d", k), spurious[k], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
